// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Arbitrates the single instruction-memory port between the core fetch path
// (IF stage) and the debug / program-loader requester. At most one access is
// granted per cycle. The grant is combinational from the requests. The read
// response is registered and returned to the granted requester one cycle later.
//
// Optional feature: define IMEM_ARB_RANGE_CHECK_EN to enable the address range
// check against DEPTH_WORDS. Out-of-range reads then return a NOP
// (32'h00000013) and out-of-range writes are dropped, but they still respond.
// Without the macro every address is treated as in range and passes straight
// through to the memory.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in instruction memory
//   STARVE_MAX   consecutive lost cycles before a waiting debug request is
//                forced through (1..15)
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   if_req/if_addr/if_flush           fetch request, byte address, flush
//   if_gnt/if_rvalid/if_rdata         fetch grant, response valid, instruction
//   dbg_req/dbg_we/dbg_addr/dbg_wdata debug request, write flag, addr, data
//   dbg_halt                          blocks all fetch grants while high
//   dbg_gnt/dbg_rvalid/dbg_rdata      debug grant, response valid, read word
//   mem_addr/mem_we/mem_wdata         shared memory port (word aligned)
//   mem_rdata                         combinational memory read data
//
// Response FSM (resp_src)
//   state      | meaning
//   RESP_IDLE  | no response presented this cycle
//   RESP_FETCH | fetch response presented this cycle
//   RESP_DBG   | debug response presented this cycle
// -----------------------------------------------------------------------------
module imem_arbiter #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic        dbg_halt,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    RESP_IDLE  = 2'd0,
    RESP_FETCH = 2'd1,
    RESP_DBG   = 2'd2
  } resp_src_e;

  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || DEPTH_WORDS < 1) begin : g_bad_param
    $error("imem_arbiter: STARVE_MAX must be 1..15 and DEPTH_WORDS >= 1");
  end

  resp_src_e   resp_src_q, resp_src_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;

  logic        gnt_if;
  logic        gnt_dbg;
  logic        gnt_any;
  logic [31:0] gnt_addr;
  logic        in_range;
  logic [31:0] rd_word;
  logic        unused_addr_bits;

  // Byte-offset bits are ignored; memory sees word-aligned addresses only.
  assign unused_addr_bits = ^{if_addr[1:0], dbg_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Grant logic. Gated by rst_n so that an access in flight when reset is
  // asserted is not committed (mem_we drops immediately).
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_if  = 1'b0;
    gnt_dbg = 1'b0;
    if (rst_n) begin
      if (dbg_halt) begin
        gnt_dbg = dbg_req;
      end else if (dbg_req && (starve_cnt_q == STARVE_LIM)) begin
        gnt_dbg = 1'b1;
      end else if (if_req) begin
        gnt_if = 1'b1;
      end else if (dbg_req) begin
        gnt_dbg = 1'b1;
      end
    end
  end

  assign gnt_any  = gnt_if | gnt_dbg;
  assign gnt_addr = gnt_dbg ? dbg_addr : if_addr;

`ifdef IMEM_ARB_RANGE_CHECK_EN
  assign in_range = (gnt_addr[31:2] < 30'(DEPTH_WORDS));
`else
  assign in_range = 1'b1;
`endif

  assign rd_word = in_range ? mem_rdata : NOP_INSN;

  assign if_gnt    = gnt_if;
  assign dbg_gnt   = gnt_dbg;
  assign mem_addr  = gnt_any ? {gnt_addr[31:2], 2'b00} : 32'h0;
  assign mem_we    = gnt_dbg & dbg_we & in_range;
  assign mem_wdata = gnt_any ? dbg_wdata : 32'h0;

  // ---------------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles a pending debug request has
  // lost to fetch, saturating at the limit so the forced grant stays armed.
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt_dbg || !dbg_req) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FSM: next state follows the grant each cycle. The per-requester
  // data registers only load on their own grant so the last response holds.
  // ---------------------------------------------------------------------------
  always_comb begin
    resp_src_d  = RESP_IDLE;
    if_rdata_d  = if_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    if (gnt_dbg) begin
      resp_src_d  = RESP_DBG;
      dbg_rdata_d = dbg_we ? 32'h0 : rd_word;
    end else if (gnt_if) begin
      resp_src_d = RESP_FETCH;
      if_rdata_d = rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_src_q   <= RESP_IDLE;
      starve_cnt_q <= 4'd0;
      if_rdata_q   <= 32'h0;
      dbg_rdata_q  <= 32'h0;
    end else begin
      resp_src_q   <= resp_src_d;
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // A flush only suppresses the valid; the fetch grant in the same cycle is
  // independent of it.
  assign if_rvalid  = (resp_src_q == RESP_FETCH) && !if_flush;
  assign dbg_rvalid = (resp_src_q == RESP_DBG);
  assign if_rdata   = if_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_halt;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];

  int n_cmp = 0;
  int n_bad = 0;

  imem_arbiter #(.DEPTH_WORDS(1024), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_halt  (dbg_halt),
    .dbg_gnt   (dbg_gnt),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata (dbg_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple instruction memory: combinational read, write at the clock edge,
  // upper address bits ignored (wraps).
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_halt;
    logic        x_if_gnt;
    logic        x_dbg_gnt;
    logic [31:0] x_mem_addr;
    logic        x_mem_we;
    logic [31:0] x_mem_wdata;
    logic        x_if_rvalid;
    logic [31:0] x_if_rdata;
    logic        x_dbg_rvalid;
    logic [31:0] x_dbg_rdata;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vec [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = 32'h0;
    if_flush  = 1'b0;
    dbg_req   = 1'b0;
    dbg_we    = 1'b0;
    dbg_addr  = 32'h0;
    dbg_wdata = 32'h0;
    dbg_halt  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " if_gnt"},     32'(if_gnt), 32'h0);
    chk({tag, " dbg_gnt"},    32'(dbg_gnt), 32'h0);
    chk({tag, " if_rvalid"},  32'(if_rvalid), 32'h0);
    chk({tag, " dbg_rvalid"}, 32'(dbg_rvalid), 32'h0);
    chk({tag, " if_rdata"},   if_rdata, 32'h0);
    chk({tag, " dbg_rdata"},  dbg_rdata, 32'h0);
    chk({tag, " mem_we"},     32'(mem_we), 32'h0);
    chk({tag, " mem_addr"},   mem_addr, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 + 32'(i);

    //       if_req addr        flush dreq dwe dbg_addr     dbg_wdata     halt | ifg dg  mem_addr     we  mem_wdata     ifv if_rdata      dv  dbg_rdata
    vec[0]  = '{0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  0, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 32'h0000_0000};
    vec[1]  = '{1, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  1, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 32'h0000_0000};
    vec[2]  = '{1, 32'h0000_0004, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  1, 0, 32'h0000_0004, 0, 32'h0000_0000, 1, 32'hC000_0000, 0, 32'h0000_0000};
    vec[3]  = '{1, 32'h0000_0008, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  1, 0, 32'h0000_0008, 0, 32'h0000_0000, 1, 32'hC000_0001, 0, 32'h0000_0000};
    vec[4]  = '{0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  0, 0, 32'h0000_0000, 0, 32'h0000_0000, 1, 32'hC000_0002, 0, 32'h0000_0000};
    vec[5]  = '{0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  0, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 32'hC000_0002, 0, 32'h0000_0000};
    // halted load: write then read-back of the same word
    vec[6]  = '{1, 32'h0000_0000, 0, 1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 1,  0, 1, 32'h0000_0010, 1, 32'hDEAD_BEEF, 0, 32'hC000_0002, 0, 32'h0000_0000};
    vec[7]  = '{1, 32'h0000_0000, 0, 1, 0, 32'h0000_0010, 32'h0000_0000, 1,  0, 1, 32'h0000_0010, 0, 32'h0000_0000, 0, 32'hC000_0002, 1, 32'h0000_0000};
    vec[8]  = '{1, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 1,  0, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 32'hC000_0002, 1, 32'hDEAD_BEEF};
    // flush of the 0x20 response while 0x40 is being granted
    vec[9]  = '{1, 32'h0000_0020, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  1, 0, 32'h0000_0020, 0, 32'h0000_0000, 0, 32'hC000_0002, 0, 32'hDEAD_BEEF};
    vec[10] = '{1, 32'h0000_0040, 1, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  1, 0, 32'h0000_0040, 0, 32'h0000_0000, 0, 32'hC000_0008, 0, 32'hDEAD_BEEF};
    vec[11] = '{0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  0, 0, 32'h0000_0000, 0, 32'h0000_0000, 1, 32'hC000_0010, 0, 32'hDEAD_BEEF};
    // unaligned debug read alone: granted at once, low bits stripped
    vec[12] = '{0, 32'h0000_0000, 0, 1, 0, 32'h0000_0023, 32'h0000_0000, 0,  0, 1, 32'h0000_0020, 0, 32'h0000_0000, 0, 32'hC000_0010, 0, 32'hDEAD_BEEF};
    vec[13] = '{0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  0, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 32'hC000_0010, 1, 32'hC000_0008};
    // unaligned fetch, last in-range word
    vec[14] = '{1, 32'h0000_0FFF, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  1, 0, 32'h0000_0FFC, 0, 32'h0000_0000, 0, 32'hC000_0010, 0, 32'hC000_0008};
    vec[15] = '{0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  0, 0, 32'h0000_0000, 0, 32'h0000_0000, 1, 32'hC000_03FF, 0, 32'hC000_0008};

    idle_inputs();
    rst_n = 1'b0;
    #2;
    check_idle_outputs("reset");
    #10 rst_n = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      if_req    = vec[i].if_req;
      if_addr   = vec[i].if_addr;
      if_flush  = vec[i].if_flush;
      dbg_req   = vec[i].dbg_req;
      dbg_we    = vec[i].dbg_we;
      dbg_addr  = vec[i].dbg_addr;
      dbg_wdata = vec[i].dbg_wdata;
      dbg_halt  = vec[i].dbg_halt;
      @(negedge clk);
      chk($sformatf("v%0d if_gnt", i),     32'(if_gnt),     32'(vec[i].x_if_gnt));
      chk($sformatf("v%0d dbg_gnt", i),    32'(dbg_gnt),    32'(vec[i].x_dbg_gnt));
      chk($sformatf("v%0d mem_addr", i),   mem_addr,        vec[i].x_mem_addr);
      chk($sformatf("v%0d mem_we", i),     32'(mem_we),     32'(vec[i].x_mem_we));
      chk($sformatf("v%0d mem_wdata", i),  mem_wdata,       vec[i].x_mem_wdata);
      chk($sformatf("v%0d if_rvalid", i),  32'(if_rvalid),  32'(vec[i].x_if_rvalid));
      chk($sformatf("v%0d if_rdata", i),   if_rdata,        vec[i].x_if_rdata);
      chk($sformatf("v%0d dbg_rvalid", i), 32'(dbg_rvalid), 32'(vec[i].x_dbg_rvalid));
      chk($sformatf("v%0d dbg_rdata", i),  dbg_rdata,       vec[i].x_dbg_rdata);
    end

    // ---------------- contention / starvation ----------------
    // Two full rounds: the second proves the counter cleared on the grant.
    for (int r = 0; r < 2; r++) begin
      for (int c = 1; c <= 5; c++) begin
        @(posedge clk); #1;
        idle_inputs();
        if_req   = 1'b1;
        if_addr  = 32'h0;
        dbg_req  = 1'b1;
        dbg_addr = 32'h4;
        @(negedge clk);
        chk($sformatf("starve r%0d c%0d if_gnt", r, c),  32'(if_gnt),  (c < 5) ? 32'h1 : 32'h0);
        chk($sformatf("starve r%0d c%0d dbg_gnt", r, c), 32'(dbg_gnt), (c == 5) ? 32'h1 : 32'h0);
      end
      @(posedge clk); #1;
      dbg_req = 1'b0;
      @(negedge clk);
      chk($sformatf("starve r%0d after if_gnt", r), 32'(if_gnt), 32'h1);
      chk($sformatf("starve r%0d dbg_rvalid", r),   32'(dbg_rvalid), 32'h1);
      chk($sformatf("starve r%0d dbg_rdata", r),    dbg_rdata, 32'hC000_0001);
    end

    // Dropping dbg_req after two losses must clear the count.
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if_req   = 1'b1;
      if_addr  = 32'h0;
      dbg_addr = 32'h4;
      dbg_req  = (c != 3);
      @(negedge clk);
      chk($sformatf("drop c%0d if_gnt", c),  32'(if_gnt),  (c < 8) ? 32'h1 : 32'h0);
      chk($sformatf("drop c%0d dbg_gnt", c), 32'(dbg_gnt), (c == 8) ? 32'h1 : 32'h0);
    end

    // ---------------- reset during a debug write ----------------
    @(posedge clk); #1;
    idle_inputs();
    if_req  = 1'b1;
    if_addr = 32'h0;
    @(negedge clk);
    chk("rst pre if_gnt", 32'(if_gnt), 32'h1);
    @(posedge clk); #1;
    idle_inputs();
    dbg_req   = 1'b1;
    dbg_we    = 1'b1;
    dbg_addr  = 32'h30;
    dbg_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("rst pre dbg_gnt",   32'(dbg_gnt),   32'h1);
    chk("rst pre mem_we",    32'(mem_we),    32'h1);
    chk("rst pre if_rvalid", 32'(if_rvalid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("rst mid");
    @(posedge clk); #1;
    check_idle_outputs("rst held");
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rst post%0d if_rvalid", c),  32'(if_rvalid),  32'h0);
      chk($sformatf("rst post%0d dbg_rvalid", c), 32'(dbg_rvalid), 32'h0);
    end
    chk("rst write dropped", mem[12], 32'hC000_000C);

    // ---------------- out-of-range access ----------------
    @(posedge clk); #1;
    idle_inputs();
    if_req  = 1'b1;
    if_addr = 32'h1000;
    @(negedge clk);
    chk("range fetch if_gnt",   32'(if_gnt), 32'h1);
    chk("range fetch mem_addr", mem_addr, 32'h1000);
    @(posedge clk); #1;
    idle_inputs();
    dbg_req   = 1'b1;
    dbg_we    = 1'b1;
    dbg_addr  = 32'h1000;
    dbg_wdata = 32'h0000_0055;
    @(negedge clk);
    chk("range if_rvalid", 32'(if_rvalid), 32'h1);
    chk("range dbg_gnt",   32'(dbg_gnt), 32'h1);
`ifdef IMEM_ARB_RANGE_CHECK_EN
    chk("range if_rdata",  if_rdata, 32'h0000_0013);
    chk("range mem_we",    32'(mem_we), 32'h0);
`else
    chk("range if_rdata",  if_rdata, 32'hC000_0000);
    chk("range mem_we",    32'(mem_we), 32'h1);
`endif
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("range dbg_rvalid", 32'(dbg_rvalid), 32'h1);
    chk("range dbg_rdata",  dbg_rdata, 32'h0);
`ifdef IMEM_ARB_RANGE_CHECK_EN
    chk("range mem0 kept",  mem[0], 32'hC000_0000);
`else
    chk("range mem0 wrap",  mem[0], 32'h0000_0055);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
